// File: rtl/gpu_sched_pkg.sv
// ============================================================
// Package : gpu_sched_pkg
// Desc    : Shared state encoding and default sizing for the
//           GPU command scheduler slice.
// Rev     : 1.0  initial release
// ============================================================
`timescale 1ns/1ps
`default_nettype none

package gpu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_e;

  localparam int DEF_CMD_W       = 128;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_ACK_TIMEOUT = 8;
  localparam int DEF_CNT_W       = 16;

  // Occupancy needs one extra bit so that a full FIFO reads as DEPTH.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_cmd_scheduler_if.sv
// ============================================================
// Interface : gpu_cmd_scheduler_if
// Desc      : Host command push port (valid/ready handshake).
// Rev       : 1.0  initial release
// ============================================================
`timescale 1ns/1ps
`default_nettype none

interface gpu_cmd_scheduler_if
  import gpu_sched_pkg::*;
#(
  parameter int CMD_W = DEF_CMD_W
) ();

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
// ============================================================
// Module : gpu_cmd_fifo
// Desc   : Synchronous command FIFO with flush, occupancy and
//          full/empty flags.
// Rev    : 1.0  initial release
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module gpu_cmd_fifo
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_CMD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_rd_ptr;
  logic [LW-1:0]    w_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one wrap bit so full and empty stay distinguishable.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_level   = w_level;
  assign o_full    = (w_level == LW'(DEPTH));
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Flush drops everything left, including any entry popped this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + LW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + LW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpu_cmd_scheduler.sv
// ============================================================
// Module : gpu_cmd_scheduler
// Desc   : Queues host draw commands and releases them to the
//          decoder one at a time, gated on GPU busy/idle.
// Rev    : 1.0  initial release
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module gpu_cmd_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CMD_W       = DEF_CMD_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  gpu_cmd_scheduler_if.slave            host,
  input  logic                          i_flush,
  output logic                          o_disp_valid,
  output logic [CMD_W-1:0]              o_disp_data,
  input  logic                          i_gpu_busy,
  input  logic                          i_gpu_done,
  output logic [level_width(DEPTH)-1:0] o_fifo_level,
  output logic                          o_sched_idle,
  output logic                          o_timeout_err,
  output logic [CNT_W-1:0]              o_issued_cnt
);

  localparam int LW = level_width(DEPTH);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE      = 2'(IDLE);
  localparam logic [1:0] S_WAIT_ACK  = 2'(WAIT_ACK);
  localparam logic [1:0] S_WAIT_DONE = 2'(WAIT_DONE);

  logic [1:0]       r_state;
  logic [TW-1:0]    r_timer;
  logic             r_disp_valid;
  logic [CMD_W-1:0] r_disp_data;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_issued_cnt;

  logic             w_full;
  logic             w_empty;
  logic [CMD_W-1:0] w_head;
  logic [LW-1:0]    w_level;
  logic             w_cmd_ready;
  logic             w_push;
  logic             w_dispatch;
  logic             w_render_end;
  logic             w_unused_done;

  assign w_cmd_ready    = !w_full && !i_flush;
  assign w_push         = host.cmd_valid && w_cmd_ready;
  assign host.cmd_ready = w_cmd_ready;

  // A flush on the dispatch edge does not block it; the FIFO clears the rest.
  assign w_dispatch = (r_state == S_IDLE) && !w_empty && !i_gpu_busy;

  // Busy falling is authoritative; the done pulse adds no extra condition.
  assign w_render_end  = !i_gpu_busy;
  assign w_unused_done = i_gpu_done;

  gpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (host.cmd_data),
    .i_pop     (w_dispatch),
    .i_flush   (i_flush),
    .o_rd_data (w_head),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_disp_valid  <= 1'b0;
      r_disp_data   <= '0;
      r_timeout_err <= 1'b0;
      r_issued_cnt  <= '0;
    end else begin
      r_disp_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_disp_valid <= 1'b1;
            r_disp_data  <= w_head;
            r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            r_timer      <= '0;
            r_state      <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_gpu_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (w_render_end) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_disp_valid  = r_disp_valid;
  assign o_disp_data   = r_disp_data;
  assign o_timeout_err = r_timeout_err;
  assign o_issued_cnt  = r_issued_cnt;
  assign o_fifo_level  = w_level;
  assign o_sched_idle  = (r_state == S_IDLE) && w_empty && !r_disp_valid;

endmodule

`default_nettype wire
